// File: rtl/conv_pkg.sv
// Shared types for the convolution layer sequencer.
//   conv_seq_state_e : sequencer FSM states
//     FILL  - accepting input columns into the window
//     START - one-cycle start pulse to conv_layer
//     WAIT  - waiting for conv_layer to report done
//     OUT   - presenting the registered result downstream
package conv_pkg;

    typedef enum logic [1:0] {
        FILL,
        START,
        WAIT,
        OUT
    } conv_seq_state_e;

endpackage

// File: rtl/conv_window_buffer.sv
// Column shift register holding the DEPTH most recent input columns.
// Ports:
//   clk_i      - clock, rising edge
//   reset_n_i  - asynchronous active-low reset, clears the window
//   shift_en_i - shift the window by one column and load col_i
//   col_i      - incoming column, row r = word r
//   win_o      - window contents, [r][DEPTH-1] is the newest column
module conv_window_buffer #(
    parameter int unsigned ROWS  = 4,
    parameter int unsigned DEPTH = 2,
    parameter int unsigned WORD  = 16
) (
    input  logic                              clk_i,
    input  logic                              reset_n_i,
    input  logic                              shift_en_i,
    input  logic [ROWS-1:0][WORD-1:0]         col_i,
    output logic [ROWS-1:0][DEPTH-1:0][WORD-1:0] win_o
);

    logic [ROWS-1:0][DEPTH-1:0][WORD-1:0] win_q;

    // Older columns move toward index 0; the new column lands at DEPTH-1.
    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            win_q <= '0;
        end else if (shift_en_i) begin
            for (int unsigned r = 0; r < ROWS; r++) begin
                for (int unsigned k = 0; k + 1 < DEPTH; k++) begin
                    win_q[r][k] <= win_q[r][k+1];
                end
                win_q[r][DEPTH-1] <= col_i[r];
            end
        end
    end

    assign win_o = win_q;

endmodule

// File: rtl/conv_layer_sequencer.sv
// Streams input columns into a KERNEL_WIDTH-deep sliding window, starts
// conv_layer once per window position and returns each result as a
// valid/ready beat. One frame is INPUT_LAYER_WIDTH columns and yields
// INPUT_LAYER_WIDTH-KERNEL_WIDTH+1 beats.
// Ports:
//   clk_i        - clock, rising edge
//   reset_n_i    - asynchronous active-low reset
//   valid_i      - input column valid
//   ready_o      - column accepted this cycle when valid_i is high
//   data_i       - input column, row r = word r
//   conv_start_o - one-cycle start pulse to conv_layer
//   conv_data_o  - window to conv_layer, [r][KW-1] = newest column
//   conv_done_i  - conv_layer result ready (honoured only in WAIT)
//   conv_data_i  - conv_layer result
//   valid_o      - output beat valid
//   ready_i      - downstream accepts the beat
//   data_o       - registered result
//   last_o       - final beat of the frame, qualified by valid_o
module conv_layer_sequencer
    import conv_pkg::*;
#(
    parameter int unsigned INPUT_LAYER_HEIGHT = 4,
    parameter int unsigned INPUT_LAYER_WIDTH  = 8,
    parameter int unsigned KERNEL_HEIGHT      = 3,
    parameter int unsigned KERNEL_WIDTH       = 2,
    parameter int unsigned WORD_SIZE          = 16
) (
    input  logic clk_i,
    input  logic reset_n_i,
    input  logic valid_i,
    output logic ready_o,
    input  logic [INPUT_LAYER_HEIGHT-1:0][WORD_SIZE-1:0] data_i,
    output logic conv_start_o,
    output logic [INPUT_LAYER_HEIGHT-1:0][KERNEL_WIDTH-1:0][WORD_SIZE-1:0] conv_data_o,
    input  logic conv_done_i,
    input  logic [INPUT_LAYER_HEIGHT-KERNEL_HEIGHT:0][WORD_SIZE-1:0] conv_data_i,
    output logic valid_o,
    input  logic ready_i,
    output logic [INPUT_LAYER_HEIGHT-KERNEL_HEIGHT:0][WORD_SIZE-1:0] data_o,
    output logic last_o
);

    localparam int unsigned CW = $clog2(INPUT_LAYER_WIDTH + 1);

    if (INPUT_LAYER_WIDTH < KERNEL_WIDTH) begin : g_bad_width
        $error("conv_layer_sequencer: INPUT_LAYER_WIDTH must be >= KERNEL_WIDTH");
    end
    if (KERNEL_HEIGHT > INPUT_LAYER_HEIGHT) begin : g_bad_height
        $error("conv_layer_sequencer: KERNEL_HEIGHT must be <= INPUT_LAYER_HEIGHT");
    end

    conv_seq_state_e state_q, state_d;
    logic [CW-1:0]   col_cnt_q, col_cnt_d;
    logic [INPUT_LAYER_HEIGHT-KERNEL_HEIGHT:0][WORD_SIZE-1:0] data_q, data_d;
    logic            shift_en;

    conv_window_buffer #(
        .ROWS  (INPUT_LAYER_HEIGHT),
        .DEPTH (KERNEL_WIDTH),
        .WORD  (WORD_SIZE)
    ) u_window (
        .clk_i      (clk_i),
        .reset_n_i  (reset_n_i),
        .shift_en_i (shift_en),
        .col_i      (data_i),
        .win_o      (conv_data_o)
    );

    // Gated with the reset input so ready_o stays low while reset is held.
    assign ready_o = reset_n_i && (state_q == FILL);
    assign last_o  = (state_q == OUT) && (col_cnt_q == CW'(INPUT_LAYER_WIDTH));
    assign data_o  = data_q;

    always_comb begin
        state_d      = state_q;
        col_cnt_d    = col_cnt_q;
        data_d       = data_q;
        shift_en     = 1'b0;
        conv_start_o = 1'b0;
        valid_o      = 1'b0;
        case (state_q)
            FILL: begin
                if (valid_i && ready_o) begin
                    shift_en  = 1'b1;
                    col_cnt_d = col_cnt_q + CW'(1);
                    if (col_cnt_d >= CW'(KERNEL_WIDTH)) begin
                        state_d = START;
                    end
                end
            end
            START: begin
                conv_start_o = 1'b1;
                state_d      = WAIT;
            end
            WAIT: begin
                if (conv_done_i) begin
                    data_d  = conv_data_i;
                    state_d = OUT;
                end
            end
            OUT: begin
                valid_o = 1'b1;
                if (ready_i) begin
                    // Frame ends here; the window is left as-is since the next
                    // frame overwrites it fully before its first START.
                    if (col_cnt_q == CW'(INPUT_LAYER_WIDTH)) begin
                        col_cnt_d = '0;
                    end
                    state_d = FILL;
                end
            end
            default: state_d = FILL;
        endcase
    end

    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            state_q   <= FILL;
            col_cnt_q <= '0;
            data_q    <= '0;
        end else begin
            state_q   <= state_d;
            col_cnt_q <= col_cnt_d;
            data_q    <= data_d;
        end
    end

endmodule

// File: tb/tb_conv_layer_sequencer.sv
// Directed bench for conv_layer_sequencer with a conv_layer stub that
// raises done five cycles after each start pulse.
module tb_conv_layer_sequencer;

    localparam int H  = 4;
    localparam int W  = 8;
    localparam int KH = 3;
    localparam int KW = 2;
    localparam int WS = 16;
    localparam int BEATS_PER_FRAME = W - KW + 1;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic reset_n, valid_i, ready_o, conv_start, conv_done, valid_o, ready_i, last_o;
    logic [H-1:0][WS-1:0]         data_i;
    logic [H-1:0][KW-1:0][WS-1:0] conv_data_o;
    logic [H-KH:0][WS-1:0]        conv_data_i, data_o;
    logic spur;
    int   stub_cnt;

    int checks = 0;
    int fails  = 0;

    localparam logic [31:0] RESULT = 32'h002d_002f;

    conv_layer_sequencer #(
        .INPUT_LAYER_HEIGHT (H),
        .INPUT_LAYER_WIDTH  (W),
        .KERNEL_HEIGHT      (KH),
        .KERNEL_WIDTH       (KW),
        .WORD_SIZE          (WS)
    ) dut (
        .clk_i        (clk),
        .reset_n_i    (reset_n),
        .valid_i      (valid_i),
        .ready_o      (ready_o),
        .data_i       (data_i),
        .conv_start_o (conv_start),
        .conv_data_o  (conv_data_o),
        .conv_done_i  (conv_done),
        .conv_data_i  (conv_data_i),
        .valid_o      (valid_o),
        .ready_i      (ready_i),
        .data_o       (data_o),
        .last_o       (last_o)
    );

    // conv_layer stub
    assign conv_data_i = RESULT;
    assign conv_done   = (stub_cnt == 1) || spur;
    always @(posedge clk or negedge reset_n) begin
        if (!reset_n)          stub_cnt <= 0;
        else if (conv_start)   stub_cnt <= 5;
        else if (stub_cnt > 0) stub_cnt <= stub_cnt - 1;
    end

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [H-1:0][KW-1:0][WS-1:0] win2(
        input logic [H-1:0][WS-1:0] newer, input logic [H-1:0][WS-1:0] older);
        logic [H-1:0][KW-1:0][WS-1:0] w;
        for (int r = 0; r < H; r++) begin
            w[r][1] = newer[r];
            w[r][0] = older[r];
        end
        return w;
    endfunction

    task automatic wait_valid(input string tag);
        int n = 0;
        while (!valid_o && n < 30) begin
            @(negedge clk);
            n++;
        end
        check(tag, valid_o, 1'b1);
    endtask

    task automatic run_frames(input int n_beats);
        int starts = 0;
        int beats  = 0;
        int cyc    = 0;
        ready_i = 1'b1;
        valid_i = 1'b1;
        while (beats < n_beats && cyc < 400) begin
            data_i = {$urandom(), $urandom()};
            @(negedge clk);
            cyc++;
            if (conv_start) starts++;
            if (valid_o) begin
                beats++;
                check("frame beat data", data_o, RESULT);
                check("frame beat last", last_o, (beats % BEATS_PER_FRAME) == 0);
                if (beats == n_beats) valid_i = 1'b0;
            end
        end
        repeat (20) begin
            @(negedge clk);
            if (conv_start) starts++;
            if (valid_o) beats++;
        end
        check("frame start count", starts, n_beats);
        check("frame beat count", beats, n_beats);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: observed no end of test, required completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [H-1:0][WS-1:0] col_a, col_b, col_c, col_d, col_e, col_f;
        col_a = 64'h0001_0002_0002_0001;
        col_b = 64'h0003_0001_0001_0001;
        col_c = 64'h1111_2222_3333_4444;
        col_d = 64'h5555_6666_7777_8888;
        col_e = 64'h9999_aaaa_bbbb_cccc;
        col_f = 64'hdddd_eeee_ffff_0123;

        reset_n = 1'b0;
        valid_i = 1'b0;
        ready_i = 1'b0;
        data_i  = '0;
        spur    = 1'b0;

        // Reset state
        #12;
        check("reset ready_o", ready_o, 1'b0);
        check("reset valid_o", valid_o, 1'b0);
        check("reset conv_start_o", conv_start, 1'b0);
        check("reset last_o", last_o, 1'b0);
        check("reset data_o", data_o, '0);
        check("reset window", conv_data_o, '0);
        @(negedge clk);
        reset_n = 1'b1;
        @(negedge clk);
        check("post-reset ready_o", ready_o, 1'b1);

        // Fill: A then B
        data_i  = col_a;
        valid_i = 1'b1;
        @(negedge clk);
        check("fill A no start", conv_start, 1'b0);
        check("fill A ready_o", ready_o, 1'b1);
        data_i = col_b;
        @(negedge clk);
        valid_i = 1'b0;
        check("fill B ready_o", ready_o, 1'b0);
        check("fill B start pulse", conv_start, 1'b1);
        check("fill B window", conv_data_o, win2(col_b, col_a));
        @(negedge clk);
        check("wait start low", conv_start, 1'b0);
        check("wait window stable", conv_data_o, win2(col_b, col_a));
        wait_valid("beat1 valid");
        check("beat1 data", data_o, RESULT);
        check("beat1 last", last_o, 1'b0);

        // Backpressure for 10 cycles
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            check("bp valid_o", valid_o, 1'b1);
            check("bp data_o", data_o, RESULT);
            check("bp ready_o", ready_o, 1'b0);
            check("bp no start", conv_start, 1'b0);
        end
        ready_i = 1'b1;
        @(negedge clk);
        check("bp release valid_o", valid_o, 1'b0);
        check("bp release ready_o", ready_o, 1'b1);

        // Spurious done in FILL
        spur = 1'b1;
        @(negedge clk);
        spur = 1'b0;
        check("spur fill valid_o", valid_o, 1'b0);
        check("spur fill ready_o", ready_o, 1'b1);
        check("spur fill no start", conv_start, 1'b0);

        // Spurious done in START
        data_i  = col_c;
        valid_i = 1'b1;
        @(negedge clk);
        valid_i = 1'b0;
        check("col C start", conv_start, 1'b1);
        check("col C window", conv_data_o, win2(col_c, col_b));
        spur = 1'b1;
        @(negedge clk);
        spur = 1'b0;
        check("spur start valid_o", valid_o, 1'b0);
        check("spur start ready_o", ready_o, 1'b0);
        check("spur start no start", conv_start, 1'b0);
        @(negedge clk);
        check("spur start still waiting", valid_o, 1'b0);
        wait_valid("beat C valid");
        check("beat C data", data_o, RESULT);
        @(negedge clk);

        // Reset during WAIT
        data_i  = col_d;
        valid_i = 1'b1;
        @(negedge clk);
        valid_i = 1'b0;
        check("col D start", conv_start, 1'b1);
        @(negedge clk);
        check("col D wait valid_o", valid_o, 1'b0);
        #1 reset_n = 1'b0;
        #1;
        check("midreset valid_o", valid_o, 1'b0);
        check("midreset conv_start_o", conv_start, 1'b0);
        check("midreset data_o", data_o, '0);
        check("midreset ready_o", ready_o, 1'b0);
        check("midreset window", conv_data_o, '0);
        @(negedge clk);
        reset_n = 1'b1;
        #1;
        check("midreset release ready_o", ready_o, 1'b1);
        data_i  = col_e;
        valid_i = 1'b1;
        @(negedge clk);
        check("refill one col no start", conv_start, 1'b0);
        check("refill one col ready_o", ready_o, 1'b1);
        data_i = col_f;
        @(negedge clk);
        valid_i = 1'b0;
        check("refill two cols start", conv_start, 1'b1);
        check("refill window", conv_data_o, win2(col_f, col_e));
        wait_valid("refill beat valid");
        check("refill beat data", data_o, RESULT);
        @(negedge clk);

        // Clean frame boundary
        reset_n = 1'b0;
        @(negedge clk);
        reset_n = 1'b1;
        @(negedge clk);

        // One full frame, then two back-to-back frames
        run_frames(BEATS_PER_FRAME);
        run_frames(2 * BEATS_PER_FRAME);

        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule
